// File: rtl/rot_pkg.sv
// Shared types for the image rotation controller: rotation encodings,
// FSM state encoding and the default pixel width.
package rot_pkg;

    localparam int PIX_W_DEF = 8;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD,
        S_WR,
        S_DONE
    } state_e;

    // Counter-clockwise by MODE quarter turns equals clockwise by (4-MODE) mod 4.
    function automatic rot_e eff_rot(input logic [1:0] mode, input logic dir);
        return dir ? rot_e'(2'd0 - mode) : rot_e'(mode);
    endfunction

endpackage

// File: rtl/rot_ctrl_if.sv
// Pixel read/write request-acknowledge channels between the rotation
// controller (master) and the memory fabric (slave).
interface rot_ctrl_if #(
    parameter int PIX_W = rot_pkg::PIX_W_DEF
);
    logic             rd_req;
    logic [31:0]      rd_addr;
    logic             rd_ack;
    logic [PIX_W-1:0] rd_data;
    logic             wr_req;
    logic [31:0]      wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic             wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_ack, rd_data, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_ack, rd_data, wr_ack
    );
endinterface

// File: rtl/rot_addr_gen.sv
// Combinational address generator: raster-order source address and the
// rotated destination address for the pixel at (x, y).
module rot_addr_gen
    import rot_pkg::*;
(
    input  logic [31:0] src,
    input  logic [31:0] dst,
    input  logic [15:0] h,
    input  logic [15:0] w,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  rot_e        rot,
    output logic [31:0] rd_addr,
    output logic [31:0] wr_addr
);
    logic [31:0] h32, w32, x32, y32, x_rev, y_rev;

    // All arithmetic is 32-bit and wraps modulo 2^32.
    assign h32   = {16'd0, h};
    assign w32   = {16'd0, w};
    assign x32   = {16'd0, x};
    assign y32   = {16'd0, y};
    assign x_rev = w32 - x32 - 32'd1;
    assign y_rev = h32 - y32 - 32'd1;

    assign rd_addr = src + y32 * w32 + x32;

    always_comb begin
        wr_addr = dst + y32 * w32 + x32;
        case (rot)
            ROT_0:   wr_addr = dst + y32 * w32 + x32;
            ROT_90:  wr_addr = dst + x32 * h32 + y_rev;
            ROT_180: wr_addr = dst + y_rev * w32 + x_rev;
            ROT_270: wr_addr = dst + x_rev * h32 + y32;
            default: wr_addr = dst + y32 * w32 + x32;
        endcase
    end

endmodule

// File: rtl/rot_ctrl.sv
// Image rotation controller: walks the source image in raster order, moving
// one pixel per read/write handshake pair to its rotated destination.
module rot_ctrl
    import rot_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic        I_ROTCTRL_PCLK,
    input  logic        I_ROTCTRL_PRESET,
    input  logic [31:0] I_ROTCTRL_SRC_IMG,
    input  logic [31:0] I_ROTCTRL_DST_IMG,
    input  logic [15:0] I_ROTCTRL_IMG_H,
    input  logic [15:0] I_ROTCTRL_IMG_W,
    input  logic [1:0]  I_ROTCTRL_MODE,
    input  logic        I_ROTCTRL_DIR,
    input  logic        I_ROTCTRL_START,
    input  logic        I_ROTCTRL_SOFT_RESET,
    input  logic        I_ROTCTRL_INTR_MASK,
    input  logic        I_ROTCTRL_INTR_CLEAR,
    rot_ctrl_if.master  mem,
    output logic [15:0] O_ROTCTRL_NEW_H,
    output logic [15:0] O_ROTCTRL_NEW_W,
    output logic        O_ROTCTRL_BUSY,
    output logic        O_ROTCTRL_DONE,
    output logic        O_ROTCTRL_INTR
);
    state_e           state_q, state_d;
    logic             start_q, start_arm_q, start_rise;
    logic [31:0]      src_q, dst_q;
    logic [15:0]      h_q, w_q, x_q, y_q, new_h_q, new_w_q;
    rot_e             rot_q, load_rot;
    logic [PIX_W-1:0] pix_q;
    logic             done_flag_q;
    logic             rd_req, wr_req, busy, done, load_en, rd_cap, wr_adv, last_pix;
    logic [31:0]      rd_addr, wr_addr;

    // A START level already high when reset releases must fall before it can launch.
    assign start_rise = I_ROTCTRL_START & ~start_q & start_arm_q;
    assign load_rot   = eff_rot(I_ROTCTRL_MODE, I_ROTCTRL_DIR);
    assign last_pix   = (x_q == w_q - 16'd1) && (y_q == h_q - 16'd1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge I_ROTCTRL_PCLK) begin
        if (I_ROTCTRL_PRESET) state_q <= S_IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d = state_q;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        load_en = 1'b0;
        rd_cap  = 1'b0;
        wr_adv  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start_rise) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_en = 1'b1;
                state_d = (I_ROTCTRL_IMG_H == 16'd0 || I_ROTCTRL_IMG_W == 16'd0) ? S_DONE : S_RD;
            end
            S_RD: begin
                rd_req = 1'b1;
                if (mem.rd_ack) begin
                    rd_cap  = 1'b1;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                wr_req = 1'b1;
                if (mem.wr_ack) begin
                    wr_adv  = 1'b1;
                    state_d = last_pix ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything: requests stay up this cycle, drop next.
        if (I_ROTCTRL_SOFT_RESET) begin
            state_d = S_IDLE;
            done    = 1'b0;
            load_en = 1'b0;
            rd_cap  = 1'b0;
            wr_adv  = 1'b0;
        end
    end

    always_ff @(posedge I_ROTCTRL_PCLK) begin
        if (I_ROTCTRL_PRESET) begin
            start_q     <= 1'b0;
            start_arm_q <= 1'b0;
        end else begin
            start_q <= I_ROTCTRL_START;
            if (!I_ROTCTRL_START) start_arm_q <= 1'b1;
        end
    end

    always_ff @(posedge I_ROTCTRL_PCLK) begin
        if (I_ROTCTRL_PRESET) begin
            src_q   <= '0;
            dst_q   <= '0;
            h_q     <= '0;
            w_q     <= '0;
            rot_q   <= ROT_0;
            x_q     <= '0;
            y_q     <= '0;
            new_h_q <= '0;
            new_w_q <= '0;
            pix_q   <= '0;
        end else begin
            if (load_en) begin
                src_q   <= I_ROTCTRL_SRC_IMG;
                dst_q   <= I_ROTCTRL_DST_IMG;
                h_q     <= I_ROTCTRL_IMG_H;
                w_q     <= I_ROTCTRL_IMG_W;
                rot_q   <= load_rot;
                x_q     <= '0;
                y_q     <= '0;
                new_h_q <= (load_rot inside {ROT_90, ROT_270}) ? I_ROTCTRL_IMG_W : I_ROTCTRL_IMG_H;
                new_w_q <= (load_rot inside {ROT_90, ROT_270}) ? I_ROTCTRL_IMG_H : I_ROTCTRL_IMG_W;
            end else if (wr_adv) begin
                if (x_q == w_q - 16'd1) begin
                    x_q <= '0;
                    y_q <= y_q + 16'd1;
                end else begin
                    x_q <= x_q + 16'd1;
                end
            end
            if (rd_cap) pix_q <= mem.rd_data;
        end
    end

    // A completion in the same cycle as a clear keeps the flag set.
    always_ff @(posedge I_ROTCTRL_PCLK) begin
        if (I_ROTCTRL_PRESET)          done_flag_q <= 1'b0;
        else if (done)                 done_flag_q <= 1'b1;
        else if (I_ROTCTRL_INTR_CLEAR) done_flag_q <= 1'b0;
    end

    rot_addr_gen u_addr_gen (
        .src     (src_q),
        .dst     (dst_q),
        .h       (h_q),
        .w       (w_q),
        .x       (x_q),
        .y       (y_q),
        .rot     (rot_q),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr)
    );

    assign mem.rd_req  = rd_req;
    assign mem.rd_addr = rd_req ? rd_addr : '0;
    assign mem.wr_req  = wr_req;
    assign mem.wr_addr = wr_req ? wr_addr : '0;
    assign mem.wr_data = wr_req ? pix_q : '0;

    assign O_ROTCTRL_NEW_H = new_h_q;
    assign O_ROTCTRL_NEW_W = new_w_q;
    assign O_ROTCTRL_BUSY  = busy;
    assign O_ROTCTRL_DONE  = done;
    assign O_ROTCTRL_INTR  = done_flag_q & ~I_ROTCTRL_INTR_MASK;

endmodule
